serial_paralelo: RTL
====================

Name: serial_paralelo

Overview:
- Receive end of the parallel-to-serial link: deserialises the 1-bit MSB-first stream on clk_32f back into bytes.
- Recovers byte alignment by hunting for the 0xBC comma the transmitter sends while idle.
- Declares the link active after COMMA_COUNT consecutive aligned commas, then presents data bytes with a valid flag; commas are stripped.
- Sits between the serial line and the downstream byte-wide logic.

Parameters:
COMMA, 8'hBC, idle/alignment symbol sent by the transmitter when valid_in is low
COMMA_COUNT, 4, consecutive aligned commas required before entering ACTIVE (range 1..15)

Ports:
clk_32f  input  1  bit clock, one serial bit per rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk_32f rising edge)
in_serial  input  1  serial data, MSB first
data_out  output  8  last received data byte
valid_out  output  1  high while data_out holds a data (non-comma) byte from the latest byte slot
byte_strobe  output  1  one-cycle pulse at every aligned byte boundary
active  output  1  high once alignment is confirmed

Behaviour:
- Reset: when reset==0 at a rising edge, all state clears: sr=0, bit_cnt=0, bc_cnt=0, state=SEARCH, data_out=8'h00, valid_out=0, byte_strobe=0, active=0. Reset mid-byte or mid-ACTIVE is honoured on that same edge; in-flight bits are discarded.
- Shift register: every cycle out of reset, sr <= {sr[6:0], in_serial}. Define w = {sr[6:0], in_serial}, the byte completing this cycle.
- SEARCH: w is compared every cycle (bit-level hunt).
  - w==COMMA -> go to ALIGN, bc_cnt=1, bit_cnt=0.
  - If COMMA_COUNT==1, go directly to ACTIVE.
- ALIGN: bit_cnt counts 0..7 and wraps; w is evaluated only when bit_cnt==7.
  - w==COMMA: bc_cnt+1; if the new count equals COMMA_COUNT -> ACTIVE and active=1 on that edge.
  - w!=COMMA: back to SEARCH, bc_cnt=0.
- ACTIVE: evaluated at bit_cnt==7; state stays ACTIVE until reset (no loss-of-sync detection).
  - byte_strobe=1 for one cycle.
  - w!=COMMA: data_out<=w, valid_out<=1.
  - w==COMMA: data_out holds its previous value, valid_out<=0.
  - valid_out holds its value between strobes and updates only at byte boundaries.
- byte_strobe pulses in ALIGN and ACTIVE byte boundaries; it is always 0 in SEARCH.
- Latency: all outputs are registered and visible in the cycle after the last bit of a byte is sampled. A byte's MSB enters on cycle k; data_out/valid_out change after edge k+7.
- Bit-slip: a false 0xBC match in SEARCH that is not repeated on the next byte boundary returns the block to SEARCH. Commas split across boundaries never count in ALIGN.
- Widths: bit_cnt 3 bits wraps 7->0; bc_cnt 4 bits, saturates at COMMA_COUNT.

Decomposition:
- Shared package/header: COMMA value and state encodings SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2. The same COMMA constant is shared with the parallel-to-serial transmitter.
- No sub-module needed; one module with an FSM and a shift/counter datapath.
- The existing transmitter serves as the reference model in the bench. Chain it back-to-back, driving valid_in/in_serial[7:0] and feeding its out_serial to in_serial.

Test Plan:
- Hold reset=0 for 3 cycles while in_serial toggles -> all outputs 0 and state SEARCH; after release with in_serial=0, outputs stay 0.
- Send 3 leading junk bits 101, then 4 x 0xBC -> first byte_strobe 8 cycles after the first comma completes; active=1 after the 4th comma boundary; valid_out stays 0 throughout.
- After lock, send 0x5A, 0xBC, 0x3C -> data_out=0x5A with valid_out=1; then valid_out=0 with data_out still 0x5A; then data_out=0x3C with valid_out=1; each update spaced 8 cycles.
- Send 2 x 0xBC then 0x11 before the count is reached -> returns to SEARCH, active=0; a following 4 x 0xBC then locks.
- Embedded false comma: stream 0x0B,0xC0 (the bits contain 1011 1100 across the boundary) before the real commas -> SEARCH matches, the next boundary fails, back to SEARCH; lock occurs only on the true aligned commas.
- Pull reset low mid-ACTIVE, 4 bits into byte 0x77 -> outputs clear on that edge; after release, re-lock requires 4 fresh commas.

Source files
------------

// File: rtl/serial_paralelo_pkg.sv
// Shared constants for the serial link: comma symbol and receiver FSM encodings.
package serial_paralelo_pkg;

  // Idle/alignment symbol; the parallel-to-serial transmitter uses the same value.
  localparam logic [7:0] COMMA = 8'hBC;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StAlign  = 2'd1,
    StActive = 2'd2
  } state_e;

endpackage

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: deserialises an MSB-first bit stream, hunts for comma
// alignment, locks after COMMA_COUNT aligned commas and presents data bytes with a valid flag.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter int unsigned COMMA_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_serial,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [3:0] CommaCnt = COMMA_COUNT[3:0];

  state_e     state_q, state_d;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;

  // Byte completing on this edge, including the bit being sampled now.
  logic [7:0] w;
  logic       boundary;
  logic       is_comma;

  assign w        = {sr_q[6:0], in_serial};
  assign boundary = (bit_cnt_q == 3'd7);
  assign is_comma = (w == COMMA);

  // State and datapath registers; synchronous active-low reset discards in-flight bits.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state_q   <= StSearch;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= w;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  // Next-state: bit-level hunt in search, byte-boundary comma counting in align.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    unique case (state_q)
      StSearch: begin
        bit_cnt_d = 3'd0;
        if (is_comma) begin
          bc_cnt_d = 4'd1;
          state_d  = (COMMA_COUNT == 1) ? StActive : StAlign;
        end
      end
      StAlign: begin
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if ((bc_cnt_q + 4'd1) == CommaCnt) begin
              state_d = StActive;
            end
          end else begin
            // Commas split across a boundary never count: restart the hunt.
            state_d   = StSearch;
            bc_cnt_d  = 4'd0;
            bit_cnt_d = 3'd0;
          end
        end
      end
      StActive: begin
        // Lock is held until reset; no loss-of-sync detection.
      end
      default: begin
        state_d   = StSearch;
        bit_cnt_d = 3'd0;
        bc_cnt_d  = 4'd0;
      end
    endcase
  end

  // Output next values: strobe on aligned boundaries, capture non-comma bytes once active.
  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    active_d = (state_d == StActive);
    if (boundary && (state_q != StSearch)) begin
      strobe_d = 1'b1;
      if (state_q == StActive) begin
        if (is_comma) begin
          valid_d = 1'b0;
        end else begin
          data_d  = w;
          valid_d = 1'b1;
        end
      end
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule
